mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : fetch/data arbiter onto one memory port, tie-alternating, with
//               busy-timeout abort and registered outputs.          rev 1.0
// ============================================================================
module mem_arbiter #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [BIT_WIDTH-1:0] i_addr,
  output logic [BIT_WIDTH-1:0] i_rdata,
  output logic                 i_ack_n,
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic [1:0]           d_size,
  input  logic [BIT_WIDTH-1:0] d_addr,
  input  logic [BIT_WIDTH-1:0] d_wdata,
  output logic [BIT_WIDTH-1:0] d_rdata,
  output logic                 d_ack_n,
  output logic                 m_req,
  output logic                 m_write,
  output logic [1:0]           m_size,
  output logic [BIT_WIDTH-1:0] m_addr,
  output logic [BIT_WIDTH-1:0] m_wdata,
  input  logic [BIT_WIDTH-1:0] m_rdata,
  input  logic                 m_ack_n,
  output logic                 bus_err,
  output logic                 err_src
);

  localparam int               CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 last_d_q;
  logic                 m_req_q;
  logic                 m_write_q;
  logic [1:0]           m_size_q;
  logic [BIT_WIDTH-1:0] m_addr_q;
  logic [BIT_WIDTH-1:0] m_wdata_q;
  logic [BIT_WIDTH-1:0] i_rdata_q;
  logic [BIT_WIDTH-1:0] d_rdata_q;
  logic                 i_ack_n_q;
  logic                 d_ack_n_q;
  logic                 bus_err_q;
  logic                 err_src_q;

  logic w_i_elig;
  logic w_d_elig;
  logic w_grant_i;
  logic w_grant_d;

  // A requester whose ack is going out this cycle is still holding its level
  // request, so it must be masked to avoid a spurious re-grant.
  assign w_i_elig  = i_req & i_ack_n_q;
  assign w_d_elig  = d_req & d_ack_n_q;
  assign w_grant_i = w_i_elig & (~w_d_elig | last_d_q);
  assign w_grant_d = w_d_elig & (~w_i_elig | ~last_d_q);
  assign cnt_d     = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_d_q  <= 1'b1;
      m_req_q   <= 1'b0;
      m_write_q <= 1'b0;
      m_size_q  <= 2'b00;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_n_q <= 1'b1;
      d_ack_n_q <= 1'b1;
      bus_err_q <= 1'b0;
      err_src_q <= 1'b0;
    end else begin
      i_ack_n_q <= 1'b1;
      d_ack_n_q <= 1'b1;
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_grant_i) begin
            state_q   <= I_BUSY;
            m_req_q   <= 1'b1;
            m_write_q <= 1'b0;
            m_size_q  <= 2'b00;
            m_addr_q  <= i_addr;
            cnt_q     <= '0;
            last_d_q  <= 1'b0;
          end else if (w_grant_d) begin
            state_q   <= D_BUSY;
            m_req_q   <= 1'b1;
            m_write_q <= d_write;
            m_size_q  <= d_size;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            cnt_q     <= '0;
            last_d_q  <= 1'b1;
          end
        end
        I_BUSY, D_BUSY: begin
          // A memory ack arriving on the limit cycle completes normally.
          if (!m_ack_n) begin
            if (state_q == I_BUSY) begin
              i_rdata_q <= m_rdata;
              i_ack_n_q <= 1'b0;
            end else begin
              d_rdata_q <= m_rdata;
              d_ack_n_q <= 1'b0;
            end
            state_q <= IDLE;
            m_req_q <= 1'b0;
          end else if (cnt_d == C_CNT_LIMIT) begin
            if (state_q == I_BUSY) begin
              i_rdata_q <= '0;
              i_ack_n_q <= 1'b0;
            end else begin
              d_rdata_q <= '0;
              d_ack_n_q <= 1'b0;
            end
            bus_err_q <= 1'b1;
            err_src_q <= (state_q == D_BUSY);
            cnt_q     <= cnt_d;
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          m_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign i_rdata = i_rdata_q;
  assign i_ack_n = i_ack_n_q;
  assign d_rdata = d_rdata_q;
  assign d_ack_n = d_ack_n_q;
  assign m_req   = m_req_q;
  assign m_write = m_write_q;
  assign m_size  = m_size_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign bus_err = bus_err_q;
  assign err_src = err_src_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : vector table + randomized rounds against a transaction-level
//                  model of the fetch/data memory arbiter.           rev 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int BIT_WIDTH = 32;
  localparam int TIMEOUT   = 16;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack_n;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack_n;
  logic        m_req;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack_n;
  logic        bus_err;
  logic        err_src;

  mem_arbiter #(.BIT_WIDTH(BIT_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack_n(i_ack_n),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack_n(d_ack_n),
    .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n),
    .bus_err(bus_err), .err_src(err_src)
  );

  always #5 clk = ~clk;

  // One round: inputs of up to two concurrent requests plus what must come out.
  typedef struct {
    bit          use_i;
    bit          use_d;
    logic [31:0] i_addr;
    bit          d_write;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    int          lat_i;
    int          lat_d;
    logic [31:0] mr_i;
    logic [31:0] mr_d;
    bit          exp_first_d;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;
    bit          exp_err_i;
    bit          exp_err_d;
  } vec_t;

  int          n_chk;
  int          n_fail;
  logic [31:0] cur_i_rdata;
  logic [31:0] cur_d_rdata;
  logic [31:0] cur_wdata;
  logic        cur_err_src;
  bit          last_d;
  vec_t        tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    cur_i_rdata = '0;
    cur_d_rdata = '0;
    cur_wdata   = '0;
    cur_err_src = 1'b0;
    last_d      = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    bit          pend_i, pend_d, drop_i, drop_d, done_n, done_a, o_err, o_write;
    int          owner, busy, guard, o_lat;
    logic [31:0] o_mr, o_rd, o_addr;
    logic [1:0]  o_size;
    i_req  = v.use_i;  i_addr = v.i_addr;
    d_req  = v.use_d;  d_write = v.d_write; d_size = v.d_size;
    d_addr = v.d_addr; d_wdata = v.d_wdata;
    pend_i = v.use_i;  pend_d = v.use_d;
    drop_i = 0; drop_d = 0; owner = -1; busy = 0; guard = 0;
    o_lat = 0; o_err = 0; o_write = 0; o_mr = '0; o_rd = '0; o_addr = '0; o_size = '0;
    while ((pend_i || pend_d) && guard < 200) begin
      if (owner >= 0 && busy == o_lat && o_lat < TIMEOUT) begin
        m_ack_n = 1'b0;
        m_rdata = o_mr;
      end else begin
        m_ack_n = (owner < 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        m_rdata = $urandom;
      end
      cycle();
      guard++;
      if (drop_i) begin i_req = 1'b0; drop_i = 0; end
      if (drop_d) begin d_req = 1'b0; drop_d = 0; end
      if (owner < 0) begin
        owner = (pend_i && pend_d) ? int'(v.exp_first_d) : (pend_d ? 1 : 0);
        if (owner == 0) begin
          o_addr = v.i_addr; o_write = 0; o_size = 2'b00; o_lat = v.lat_i;
          o_mr = v.mr_i; o_rd = v.exp_i_rdata; o_err = v.exp_err_i;
        end else begin
          o_addr = v.d_addr; o_write = v.d_write; o_size = v.d_size; o_lat = v.lat_d;
          o_mr = v.mr_d; o_rd = v.exp_d_rdata; o_err = v.exp_err_d;
          cur_wdata = v.d_wdata;
        end
        busy = 0;
        chk("grant m_req", m_req, 1);
        chk("grant m_addr", m_addr, o_addr);
        chk("grant m_write/m_size", {m_write, m_size}, {o_write, o_size});
        chk("grant m_wdata", m_wdata, cur_wdata);
        chk("grant ack_n/bus_err idle", {i_ack_n, d_ack_n, bus_err}, 3'b110);
        chk("grant rdata held", {i_rdata, d_rdata}, {cur_i_rdata, cur_d_rdata});
        if (m_req !== 1'b1) break;
      end else begin
        busy++;
        done_n = (o_lat < TIMEOUT) && (busy == o_lat + 1);
        done_a = (o_lat >= TIMEOUT) && (busy == TIMEOUT);
        if (!done_n && !done_a) begin
          chk("busy m_req", m_req, 1);
          chk("busy m_addr stable", m_addr, o_addr);
          chk("busy m_write/m_size stable", {m_write, m_size}, {o_write, o_size});
          chk("busy m_wdata stable", m_wdata, cur_wdata);
          chk("busy ack_n/bus_err", {i_ack_n, d_ack_n, bus_err}, 3'b110);
          chk("busy rdata/err_src held", {i_rdata, d_rdata, err_src},
              {cur_i_rdata, cur_d_rdata, cur_err_src});
        end else begin
          if (owner == 0) cur_i_rdata = o_rd; else cur_d_rdata = o_rd;
          if (o_err) cur_err_src = (owner == 1);
          chk("done m_req", m_req, 0);
          chk("done i_ack_n", i_ack_n, (owner == 0) ? 1'b0 : 1'b1);
          chk("done d_ack_n", d_ack_n, (owner == 1) ? 1'b0 : 1'b1);
          chk("done i_rdata", i_rdata, cur_i_rdata);
          chk("done d_rdata", d_rdata, cur_d_rdata);
          chk("done bus_err", bus_err, o_err);
          chk("done err_src", err_src, cur_err_src);
          if (owner == 0) begin pend_i = 0; drop_i = 1; end
          else            begin pend_d = 0; drop_d = 1; end
          owner = -1;
        end
      end
    end
    n_chk++;
    if (pend_i || pend_d) begin
      n_fail++;
      $display("FAIL round completion: still pending fetch=%0d data=%0d after %0d cycles",
               pend_i, pend_d, guard);
    end
    m_ack_n = 1'b1;
    cycle();
    chk("tail no regrant", m_req, 0);
    chk("tail ack_n/bus_err", {i_ack_n, d_ack_n, bus_err}, 3'b110);
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   sel;
    n_chk = 0; n_fail = 0;
    clk = 0; rst = 1;
    i_req = 0; i_addr = '0; d_req = 0; d_write = 0; d_size = '0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack_n = 1'b1;

    //         use_i use_d i_addr        wr size   d_addr        d_wdata       li ld  mr_i          mr_d          1st_d exp_i         exp_d        ei ed
    tbl[0] = '{1, 1, 32'h0000_0100, 0, 2'b00, 32'h8000_0200, 32'h0000_0000, 1, 2, 32'hAAAA_0001, 32'h5555_0002, 0, 32'hAAAA_0001, 32'h5555_0002, 0, 0};
    tbl[1] = '{1, 1, 32'h0000_0104, 1, 2'b01, 32'h8000_0210, 32'hCAFE_1234, 0, 0, 32'h0BAD_0003, 32'h0BAD_0004, 0, 32'h0BAD_0003, 32'h0BAD_0004, 0, 0};
    tbl[2] = '{1, 0, 32'h0000_0040, 0, 2'b00, 32'h0000_0000, 32'h0000_0000, 0, 0, 32'h0000_0013, 32'h0000_0000, 0, 32'h0000_0013, 32'h0000_0000, 0, 0};
    tbl[3] = '{1, 1, 32'h0000_0200, 0, 2'b11, 32'h8000_0301, 32'h0000_0000, 3, 0, 32'h1111_2222, 32'h3333_4444, 1, 32'h1111_2222, 32'h3333_4444, 0, 0};
    tbl[4] = '{0, 1, 32'h0000_0000, 1, 2'b10, 32'hF000_0000, 32'h0000_0041, 0, 3, 32'h0000_0000, 32'hDEAD_BEEF, 1, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0};
    tbl[5] = '{0, 1, 32'h0000_0000, 0, 2'b00, 32'h8000_0400, 32'h0000_0077, 0, 16, 32'h0000_0000, 32'h9999_9999, 1, 32'h0000_0000, 32'h0000_0000, 0, 1};
    tbl[6] = '{1, 0, 32'h0000_0300, 0, 2'b00, 32'h0000_0000, 32'h0000_0000, 15, 0, 32'h0000_1234, 32'h0000_0000, 0, 32'h0000_1234, 32'h0000_0000, 0, 0};
    tbl[7] = '{1, 1, 32'h0000_0400, 1, 2'b01, 32'h8000_0500, 32'h0000_5A5A, 20, 15, 32'hFFFF_0000, 32'h0000_ABCD, 1, 32'h0000_0000, 32'h0000_ABCD, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset m_req/m_write/m_size", {m_req, m_write, m_size}, 4'b0000);
    chk("reset m_addr", m_addr, 0);
    chk("reset m_wdata", m_wdata, 0);
    chk("reset rdata", {i_rdata, d_rdata}, 64'h0);
    chk("reset ack_n/bus_err/err_src", {i_ack_n, d_ack_n, bus_err, err_src}, 4'b1100);
    rst = 1'b0;
    model_reset();

    for (int k = 0; k < 8; k++) run_vec(tbl[k]);

    // Memory ack while idle must be ignored.
    m_ack_n = 1'b0;
    m_rdata = 32'hFFFF_FFFF;
    cycle();
    m_ack_n = 1'b1;
    chk("idle ack m_req", m_req, 0);
    chk("idle ack ack_n/bus_err", {i_ack_n, d_ack_n, bus_err}, 3'b110);
    chk("idle ack rdata held", {i_rdata, d_rdata}, {cur_i_rdata, cur_d_rdata});

    // Reset in the middle of a fetch.
    i_req = 1'b1; i_addr = 32'h0000_0600;
    cycle();
    chk("rst seq grant", m_req, 1);
    cycle();
    cycle();
    #3 rst = 1'b1;
    #1;
    chk("rst seq async m_req", m_req, 0);
    chk("rst seq async i_ack_n/bus_err", {i_ack_n, bus_err}, 2'b10);
    chk("rst seq async m_addr", m_addr, 0);
    chk("rst seq async rdata", {i_rdata, d_rdata}, 64'h0);
    i_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cycle();
    chk("rst seq no ack pulse", {m_req, i_ack_n, d_ack_n}, 3'b011);
    v = '{1, 0, 32'h0000_0700, 0, 2'b00, 32'h0, 32'h0, 2, 0, 32'h0000_0077, 32'h0, 0,
          32'h0000_0077, 32'h0, 0, 0};
    run_vec(v);

    // Randomized rounds against the transaction model.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    model_reset();
    for (int r = 0; r < 40; r++) begin
      sel       = int'($urandom_range(1, 3));
      v.use_i   = sel[0];
      v.use_d   = sel[1];
      v.i_addr  = $urandom;
      v.d_write = 1'($urandom_range(0, 1));
      v.d_size  = 2'($urandom_range(0, 3));
      v.d_addr  = $urandom;
      v.d_wdata = $urandom;
      v.lat_i   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
      v.lat_d   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
      v.mr_i    = $urandom;
      v.mr_d    = $urandom;
      v.exp_err_i   = (v.lat_i >= TIMEOUT);
      v.exp_err_d   = (v.lat_d >= TIMEOUT);
      v.exp_i_rdata = v.exp_err_i ? 32'h0 : v.mr_i;
      v.exp_d_rdata = v.exp_err_d ? 32'h0 : v.mr_d;
      v.exp_first_d = (v.use_i && v.use_d) ? !last_d : v.use_d;
      last_d        = (v.use_i && v.use_d) ? !v.exp_first_d : v.use_d;
      run_vec(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
